// File: rtl/aes_inv_round_ctrl_if.sv
// Ciphertext-in / plaintext-out valid/ready bundle of the AES-128 inverse-round sequencer.
// slave is the controller's view, master is the producer/consumer side.
interface aes_inv_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock over an external datapath, NR+2 cycles accept-to-valid.
// Result is held in DONE until out_ready; a new block may be accepted in the same cycle the result leaves.
module aes_inv_round_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_round_ctrl_if.slave  io,
  output logic [IDX_W-1:0]     key_idx,
  input  logic [127:0]         key_in,
  output logic [127:0]         dp_state,
  output logic [1:0]           dp_mode,
  input  logic [127:0]         dp_result,
  output logic                 busy
);

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_FULL  = 2'b01;
  localparam logic [1:0] MODE_NOMIX = 2'b10;

  localparam logic [IDX_W-1:0] RND_LAST  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] RND_FIRST = IDX_W'(NR - 1);
  localparam logic [IDX_W-1:0] RND_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  fsm_t             fsm;
  logic [127:0]     state_q;
  logic [IDX_W-1:0] rnd_q;
  logic [1:0]       dp_mode_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             accept;

  // Only register state and out_ready feed in_ready; in_valid never reaches an output.
  assign io.in_ready = !rst && (fsm == IDLE || (fsm == DONE && io.out_ready));
  assign accept      = io.in_valid && io.in_ready;

  // rnd_q already holds the wanted key index in every state, so it drives key_idx directly.
  assign key_idx      = rnd_q;
  assign dp_state     = state_q;
  assign dp_mode      = dp_mode_q;
  assign busy         = busy_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      dp_mode_q   <= MODE_ADD;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE, DONE: begin
          if (accept) begin
            state_q     <= io.in_data;
            rnd_q       <= RND_LAST;
            dp_mode_q   <= MODE_ADD;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
            fsm         <= INIT;
          end else if (fsm == DONE && io.out_ready) begin
            out_valid_q <= 1'b0;
            fsm         <= IDLE;
          end
        end

        INIT: begin
          state_q <= dp_result;
          if (NR > 1) begin
            rnd_q     <= RND_FIRST;
            dp_mode_q <= MODE_FULL;
            fsm       <= ROUND;
          end else begin
            rnd_q     <= '0;
            dp_mode_q <= MODE_NOMIX;
            fsm       <= FINAL;
          end
        end

        ROUND: begin
          state_q <= dp_result;
          if (rnd_q == RND_ONE) begin
            rnd_q     <= '0;
            dp_mode_q <= MODE_NOMIX;
            fsm       <= FINAL;
          end else begin
            rnd_q <= rnd_q - RND_ONE;
          end
        end

        FINAL: begin
          state_q     <= dp_result;
          dp_mode_q   <= MODE_ADD;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          fsm         <= DONE;
        end

        default: begin
          rnd_q       <= '0;
          dp_mode_q   <= MODE_ADD;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          fsm         <= IDLE;
        end
      endcase
    end
  end

  a_mode_legal: assert property (@(posedge clk) disable iff (rst) dp_mode != 2'b11);
  a_idx_range:  assert property (@(posedge clk) disable iff (rst) key_idx <= RND_LAST);
  a_out_hold:   assert property (@(posedge clk) disable iff (rst)
                  (io.out_valid && !io.out_ready) |=> (io.out_valid && $stable(io.out_data)));

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: behavioural inverse-round datapath and key store, AES-128 encryption
// as the reference, FIPS-197 vector plus randomized blocks, backpressure, back-to-back and reset cases.
module tb_aes_inv_round_ctrl;
  localparam int NR = 10;

  logic         clk;
  logic         rst;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic [127:0] dp_state;
  logic [1:0]   dp_mode;
  logic [127:0] dp_result;
  logic         busy;

  aes_inv_round_ctrl_if io ();

  aes_inv_round_ctrl #(.NR(NR), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .key_idx   (key_idx),
    .key_in    (key_in),
    .dp_state  (dp_state),
    .dp_mode   (dp_mode),
    .dp_result (dp_result),
    .busy      (busy)
  );

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [NR+1];
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [7:0] cf(input bit fwd, input int i);
    case (i)
      0:       return fwd ? 8'h02 : 8'h0e;
      1:       return fwd ? 8'h03 : 8'h0b;
      2:       return fwd ? 8'h01 : 8'h0d;
      default: return fwd ? 8'h01 : 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit fwd);
    logic [127:0] o;
    logic [7:0]   v;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v = v ^ gm(gb(s, j, c), cf(fwd, (j - r + 4) % 4));
        o[127-8*(4*c+r) -: 8] = v;
      end
    return o;
  endfunction

  // Datapath model: InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
  function automatic logic [127:0] inv_dp(input logic [127:0] s, input logic [1:0] mode,
                                          input logic [127:0] k);
    logic [127:0] t;
    if (mode == 2'b00) return s ^ k;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = isbox[gb(s, r, (c - r + 4) % 4)];
    t = t ^ k;
    if (mode == 2'b01) t = mix(t, 1'b0);
    return t;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s, t;
    s = pt ^ rk[0];
    for (int rd = 1; rd <= NR; rd++) begin
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(4*c+r) -: 8] = sbox[gb(s, r, (c + r) % 4)];
      if (rd < NR) t = mix(t, 1'b1);
      s = t ^ rk[rd];
    end
    return s;
  endfunction

  function automatic logic [1:0] exp_mode(input int k);
    if (k == 1) return 2'b00;
    if (k == NR + 1) return 2'b10;
    return 2'b01;
  endfunction

  assign key_in    = (key_idx <= 4'(NR)) ? rk[key_idx] : '0;
  assign dp_result = inv_dp(dp_state, dp_mode, key_in);

  // Offer one block from IDLE, track every cycle, hold the result for 'hold' cycles, then drain it.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input int hold, input bit noise);
    io.in_valid  = 1'b1;
    io.in_data   = ct;
    io.out_ready = 1'b0;
    #1;
    chk("idle_in_ready", 128'(io.in_ready), 128'd1);
    @(negedge clk);
    for (int k = 1; k <= NR + 1; k++) begin
      io.in_valid = noise ? 1'($urandom % 2) : 1'b0;
      io.in_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("key_idx", 128'(key_idx), 128'(NR + 1 - k));
      chk("dp_mode", 128'(dp_mode), 128'(exp_mode(k)));
      chk("busy", 128'(busy), 128'd1);
      chk("busy_in_ready", 128'(io.in_ready), 128'd0);
      chk("early_out_valid", 128'(io.out_valid), 128'd0);
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      io.out_ready = (h == hold);
      #1;
      chk("out_valid", 128'(io.out_valid), 128'd1);
      chk("out_data", io.out_data, pt);
      chk("done_busy", 128'(busy), 128'd0);
      chk("done_key_idx", 128'(key_idx), 128'd0);
      chk("done_dp_mode", 128'(dp_mode), 128'd0);
      chk("done_in_ready", 128'(io.in_ready), 128'(io.out_ready));
      @(negedge clk);
    end
    io.out_ready = 1'b0;
    #1;
    chk("drained_out_valid", 128'(io.out_valid), 128'd0);
    chk("drained_in_ready", 128'(io.in_ready), 128'd1);
  endtask

  initial begin
    logic [31:0]  w [4*(NR+1)];
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic [127:0] key;
    logic [127:0] pa, pb, ca, cb;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb, inv, b;
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(xb, y[7:0]) == 8'h01) inv = y[7:0];
      b = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox[x]  = b;
      isbox[b] = xb;
    end

    key  = 128'h000102030405060708090a0b0c0d0e0f;
    rcon = 8'h01;
    for (int i = 0; i < 4 * (NR + 1); i++) begin
      if (i < 4) begin
        w[i] = key[127-32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % 4 == 0) begin
          tmp = {tmp[23:0], tmp[31:24]};
          tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
          tmp = tmp ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end
        w[i] = w[i-4] ^ tmp;
      end
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    io.in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 128'(io.in_ready), 128'd0);
    io.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 128'(io.out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key_idx", 128'(key_idx), 128'd0);
    chk("rst_dp_mode", 128'(dp_mode), 128'd0);
    chk("rst_out_data", io.out_data, 128'd0);
    chk("rst_idle_in_ready", 128'(io.in_ready), 128'd1);
    @(negedge clk);

    // FIPS-197 C.1 with five cycles of backpressure before release.
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 5, 1'b0);
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      pa = {$urandom, $urandom, $urandom, $urandom};
      run_block(aes_enc(pa), pa, int'($urandom_range(0, 3)), 1'b1);
      @(negedge clk);
    end

    // Back-to-back: the second block is accepted on the edge that transfers the first.
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    ca = aes_enc(pa);
    cb = aes_enc(pb);
    io.in_valid  = 1'b1;
    io.in_data   = ca;
    io.out_ready = 1'b1;
    #1;
    chk("b2b_first_ready", 128'(io.in_ready), 128'd1);
    @(negedge clk);
    io.in_data = cb;
    for (int k = 1; k <= NR + 1; k++) begin
      #1;
      chk("b2b_busy_a", 128'(busy), 128'd1);
      chk("b2b_in_ready_a", 128'(io.in_ready), 128'd0);
      @(negedge clk);
    end
    #1;
    chk("b2b_valid_a", 128'(io.out_valid), 128'd1);
    chk("b2b_data_a", io.out_data, pa);
    chk("b2b_second_ready", 128'(io.in_ready), 128'd1);
    @(negedge clk);
    io.in_valid = 1'b0;
    for (int k = 1; k <= NR + 1; k++) begin
      #1;
      chk("b2b_gap_valid", 128'(io.out_valid), 128'd0);
      chk("b2b_key_idx_b", 128'(key_idx), 128'(NR + 1 - k));
      @(negedge clk);
    end
    #1;
    chk("b2b_valid_b", 128'(io.out_valid), 128'd1);
    chk("b2b_data_b", io.out_data, pb);
    @(negedge clk);
    #1;
    chk("b2b_drained", 128'(io.out_valid), 128'd0);
    io.out_ready = 1'b0;
    @(negedge clk);

    // Reset while rnd_q == 5 discards the block; a fresh block then decrypts normally.
    pa = {$urandom, $urandom, $urandom, $urandom};
    io.in_valid = 1'b1;
    io.in_data  = aes_enc(pa);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_key_idx", 128'(key_idx), 128'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(io.in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_out_valid", 128'(io.out_valid), 128'd0);
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_state", dp_state, 128'd0);
    chk("mid_key_idx0", 128'(key_idx), 128'd0);
    chk("mid_dp_mode", 128'(dp_mode), 128'd0);
    chk("mid_in_ready", 128'(io.in_ready), 128'd1);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      #1;
      chk("mid_no_pulse", 128'(io.out_valid), 128'd0);
    end
    @(negedge clk);
    pb = {$urandom, $urandom, $urandom, $urandom};
    run_block(aes_enc(pb), pb, 1, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
